// File: rtl/tcm_ctrl_if.sv
// Fetch and load/store request/response channels between the core and tcm_ctrl.
// Signal suffixes are from the controller's point of view.
interface tcm_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req_valid_i;
  logic              if_req_ready_o;
  logic [ADDR_W-1:0] if_addr_i;
  logic              if_rsp_valid_o;
  logic              if_rsp_ready_i;
  logic [DATA_W-1:0] if_rsp_data_o;
  logic              if_rsp_err_o;

  logic                ls_req_valid_i;
  logic                ls_req_ready_o;
  logic [ADDR_W-1:0]   ls_addr_i;
  logic                ls_we_i;
  logic [DATA_W/8-1:0] ls_wmask_i;
  logic [DATA_W-1:0]   ls_wdata_i;
  logic                ls_rsp_valid_o;
  logic                ls_rsp_ready_i;
  logic [DATA_W-1:0]   ls_rsp_data_o;
  logic                ls_rsp_err_o;

  modport slave (
    input  if_req_valid_i, if_addr_i, if_rsp_ready_i,
    output if_req_ready_o, if_rsp_valid_o,
    output if_rsp_data_o, if_rsp_err_o,
    input  ls_req_valid_i, ls_addr_i, ls_we_i,
    input  ls_wmask_i, ls_wdata_i, ls_rsp_ready_i,
    output ls_req_ready_o, ls_rsp_valid_o,
    output ls_rsp_data_o, ls_rsp_err_o
  );

  modport master (
    output if_req_valid_i, if_addr_i, if_rsp_ready_i,
    input  if_req_ready_o, if_rsp_valid_o,
    input  if_rsp_data_o, if_rsp_err_o,
    output ls_req_valid_i, ls_addr_i, ls_we_i,
    output ls_wmask_i, ls_wdata_i, ls_rsp_ready_i,
    input  ls_req_ready_o, ls_rsp_valid_o,
    input  ls_rsp_data_o, ls_rsp_err_o
  );
endinterface

// File: rtl/tcm_ctrl.sv
// ITCM/DTCM controller: fetch + load/store ports, fair ITCM arbitration,
// registered back-pressurable responses with unmapped-address error.
module gnrl_ram #(
  parameter int AW = 14,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            cs_i,
  input  logic            we_i,
  input  logic [DW/8-1:0] wmask_i,
  input  logic [AW-1:0]   addr_i,
  input  logic [DW-1:0]   wdata_i,
  output logic [DW-1:0]   rdata_o
);
  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (cs_i) begin
      if (we_i) begin
        for (int b = 0; b < DW/8; b++)
          if (wmask_i[b])
            mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;
endmodule

module tcm_ctrl #(
  parameter int                ADDR_W        = 32,
  parameter int                DATA_W        = 32,
  parameter logic [ADDR_W-1:0] ITCM_BASE     = 32'h0000_0000,
  parameter int                ITCM_AW       = 14,
  parameter logic [ADDR_W-1:0] DTCM_BASE     = 32'h1000_0000,
  parameter int                DTCM_AW       = 14,
  parameter int                MAX_LS_STREAK = 4
) (
  input  logic       clk,
  input  logic       rst,
  tcm_ctrl_if.slave  bus,
  output logic       itcm_conflict_o
);
  localparam int MW = DATA_W/8;
  localparam int BW = $clog2(MW);
  localparam int SW = $clog2(MAX_LS_STREAK+1);

  localparam logic [ADDR_W:0] I_LO = {1'b0, ITCM_BASE};
  localparam logic [ADDR_W:0] I_HI =
    I_LO + ((ADDR_W+1)'(1) << (ITCM_AW+BW));
  localparam logic [ADDR_W:0] D_LO = {1'b0, DTCM_BASE};
  localparam logic [ADDR_W:0] D_HI =
    D_LO + ((ADDR_W+1)'(1) << (DTCM_AW+BW));

  typedef enum logic [1:0] {
    SRC_ZERO, SRC_ITCM, SRC_DTCM
  } src_e;

  function automatic logic hit(
    input logic [ADDR_W-1:0] a,
    input logic [ADDR_W:0]   lo,
    input logic [ADDR_W:0]   hi
  );
    return ({1'b0, a} >= lo) && ({1'b0, a} < hi);
  endfunction

  logic              if_vq, if_vd, if_eq, if_ed;
  logic              if_fq, if_fd;
  src_e              if_sq, if_sd;
  logic [DATA_W-1:0] if_hq, if_hd, if_data;

  logic              ls_vq, ls_vd, ls_eq, ls_ed;
  logic              ls_fq, ls_fd;
  src_e              ls_sq, ls_sd;
  logic [DATA_W-1:0] ls_hq, ls_hd, ls_data;

  logic [SW-1:0] streak_q, streak_d;

  logic if_itcm, ls_itcm, ls_dtcm;
  logic if_free, ls_free, if_c, ls_c;
  logic if_win, ls_win, if_acc, ls_acc;
  logic [DATA_W-1:0] itcm_rdata, dtcm_rdata;
  logic [ITCM_AW-1:0] itcm_addr;
  logic [DTCM_AW-1:0] dtcm_addr;

  assign if_itcm = hit(bus.if_addr_i, I_LO, I_HI);
  assign ls_itcm = hit(bus.ls_addr_i, I_LO, I_HI);
  assign ls_dtcm = hit(bus.ls_addr_i, D_LO, D_HI);

  assign if_free = !if_vq || bus.if_rsp_ready_i;
  assign ls_free = !ls_vq || bus.ls_rsp_ready_i;

  // Only ports able to issue this cycle compete for the ITCM
  assign if_c = bus.if_req_valid_i && if_itcm && if_free;
  assign ls_c = bus.ls_req_valid_i && ls_itcm && ls_free;

  assign ls_win = ls_c &&
    (!if_c || streak_q != SW'(MAX_LS_STREAK));
  assign if_win = if_c && !ls_win;
  assign itcm_conflict_o = if_c && ls_c;

  assign bus.if_req_ready_o = if_free && (!if_itcm || if_win);
  assign bus.ls_req_ready_o = ls_free && (!ls_itcm || ls_win);

  assign if_acc = bus.if_req_valid_i && bus.if_req_ready_o;
  assign ls_acc = bus.ls_req_valid_i && bus.ls_req_ready_o;

  assign itcm_addr = if_win ?
    ITCM_AW'((bus.if_addr_i - ITCM_BASE) >> BW) :
    ITCM_AW'((bus.ls_addr_i - ITCM_BASE) >> BW);
  assign dtcm_addr =
    DTCM_AW'((bus.ls_addr_i - DTCM_BASE) >> BW);

  gnrl_ram #(.AW(ITCM_AW), .DW(DATA_W)) u_itcm (
    .clk     (clk),
    .cs_i    (if_win || ls_win),
    .we_i    (ls_win && bus.ls_we_i),
    .wmask_i (bus.ls_wmask_i),
    .addr_i  (itcm_addr),
    .wdata_i (bus.ls_wdata_i),
    .rdata_o (itcm_rdata)
  );

  gnrl_ram #(.AW(DTCM_AW), .DW(DATA_W)) u_dtcm (
    .clk     (clk),
    .cs_i    (ls_acc && ls_dtcm),
    .we_i    (bus.ls_we_i),
    .wmask_i (bus.ls_wmask_i),
    .addr_i  (dtcm_addr),
    .wdata_i (bus.ls_wdata_i),
    .rdata_o (dtcm_rdata)
  );

  // RAM output is used only in the cycle after the read; later it is held
  always_comb begin
    if_data = if_hq;
    if (if_fq)
      if_data = (if_sq == SRC_ITCM) ? itcm_rdata : '0;
  end

  always_comb begin
    ls_data = ls_hq;
    if (ls_fq) begin
      unique case (ls_sq)
        SRC_ITCM: ls_data = itcm_rdata;
        SRC_DTCM: ls_data = dtcm_rdata;
        default:  ls_data = '0;
      endcase
    end
  end

  always_comb begin
    if_vd = if_acc || (if_vq && !bus.if_rsp_ready_i);
    if_fd = if_acc;
    if_hd = if_data;
    if_ed = if_eq;
    if_sd = if_sq;
    if (if_acc) begin
      if_ed = !if_itcm;
      if_sd = if_itcm ? SRC_ITCM : SRC_ZERO;
    end
  end

  always_comb begin
    ls_vd = ls_acc || (ls_vq && !bus.ls_rsp_ready_i);
    ls_fd = ls_acc;
    ls_hd = ls_data;
    ls_ed = ls_eq;
    ls_sd = ls_sq;
    if (ls_acc) begin
      ls_ed = !(ls_itcm || ls_dtcm);
      ls_sd = SRC_ZERO;
      if (!bus.ls_we_i && ls_itcm)
        ls_sd = SRC_ITCM;
      else if (!bus.ls_we_i && ls_dtcm)
        ls_sd = SRC_DTCM;
    end
  end

  always_comb begin
    streak_d = streak_q;
    if (if_acc)
      streak_d = '0;
    else if (ls_win && if_c &&
             streak_q != SW'(MAX_LS_STREAK))
      streak_d = streak_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_vq    <= 1'b0;
      if_eq    <= 1'b0;
      if_fq    <= 1'b0;
      if_sq    <= SRC_ZERO;
      if_hq    <= '0;
      ls_vq    <= 1'b0;
      ls_eq    <= 1'b0;
      ls_fq    <= 1'b0;
      ls_sq    <= SRC_ZERO;
      ls_hq    <= '0;
      streak_q <= '0;
    end else begin
      if_vq    <= if_vd;
      if_eq    <= if_ed;
      if_fq    <= if_fd;
      if_sq    <= if_sd;
      if_hq    <= if_hd;
      ls_vq    <= ls_vd;
      ls_eq    <= ls_ed;
      ls_fq    <= ls_fd;
      ls_sq    <= ls_sd;
      ls_hq    <= ls_hd;
      streak_q <= streak_d;
    end
  end

  assign bus.if_rsp_valid_o = if_vq;
  assign bus.if_rsp_err_o   = if_eq;
  assign bus.if_rsp_data_o  = if_data;
  assign bus.ls_rsp_valid_o = ls_vq;
  assign bus.ls_rsp_err_o   = ls_eq;
  assign bus.ls_rsp_data_o  = ls_data;
endmodule
